// File: rtl/det2_frontend_if.sv
// Handshake bundle for det2_frontend: serial entry stream in, determinant result out.
// master = stream environment (producer/consumer), slave = the front end.
interface det2_frontend_if;
  localparam int unsigned ENTRY_W = 4;
  localparam int unsigned MAG_W   = 8;

  logic               in_valid;
  logic [ENTRY_W-1:0] in_data;
  logic               in_ready;
  logic               out_valid;
  logic [MAG_W-1:0]   out_mag;
  logic               out_sign;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_mag, out_sign
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_mag, out_sign
  );
endinterface

// File: rtl/det2_frontend.sv
// Sequencing front end for the 2x2 determinant stage: assembles a,b,c,d from a nibble
// stream, samples the external a*d - c*b result once, and holds it under valid/ready.
module det2_frontend (
  input  logic                clk,
  input  logic                reset,
  det2_frontend_if.slave      bus,
  output logic [3:0]          mat_a,
  output logic [3:0]          mat_b,
  output logic [3:0]          mat_c,
  output logic [3:0]          mat_d,
  input  logic [7:0]          det_mag,
  input  logic                det_sign,
  output logic [7:0]          frame_cnt
);
  localparam int unsigned IDX_W = 2;
  localparam int unsigned MAG_W = 8;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [MAG_W-1:0]   out_mag_q;
  logic               out_sign_q;
  logic               out_valid_q;

  assign bus.in_ready  = (state == LOAD) & ~reset;
  assign bus.out_valid = out_valid_q;
  assign bus.out_mag   = out_mag_q;
  assign bus.out_sign  = out_sign_q;

  // Sequencer: operands only move on accepted entries, result captured once in EVAL.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      idx         <= '0;
      mat_a       <= '0;
      mat_b       <= '0;
      mat_c       <= '0;
      mat_d       <= '0;
      out_mag_q   <= '0;
      out_sign_q  <= 1'b0;
      out_valid_q <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.in_valid) begin
            case (idx)
              2'd0:    mat_a <= bus.in_data;
              2'd1:    mat_b <= bus.in_data;
              2'd2:    mat_c <= bus.in_data;
              default: mat_d <= bus.in_data;
            endcase
            if (idx == 2'd3) begin
              idx   <= '0;
              state <= EVAL;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        EVAL: begin
          // A zero magnitude is never reported as negative.
          out_mag_q   <= det_mag;
          out_sign_q  <= det_sign & (det_mag != '0);
          out_valid_q <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            frame_cnt   <= frame_cnt + CNT_W'(1);
            state       <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_det2_frontend.sv
// Scoreboard bench for det2_frontend with a behavioural determinant stage and a
// reference model built from accepted entries.
`timescale 1ns/1ps
module tb_det2_frontend;
  logic       clk;
  logic       reset;
  logic [3:0] mat_a, mat_b, mat_c, mat_d;
  logic [7:0] det_mag;
  logic       det_sign;
  logic [7:0] frame_cnt;
  logic       sloppy;
  int         p_det;
  int         or_mode;

  int checks;
  int failures;

  det2_frontend_if bus ();

  det2_frontend dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .mat_c     (mat_c),
    .mat_d     (mat_d),
    .det_mag   (det_mag),
    .det_sign  (det_sign),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Determinant stage; 'sloppy' makes it report negative zero to exercise normalisation.
  always_comb begin
    p_det    = int'(mat_a) * int'(mat_d) - int'(mat_c) * int'(mat_b);
    det_mag  = (p_det < 0) ? 8'(-p_det) : 8'(p_det);
    det_sign = (p_det < 0) | ((p_det == 0) & sloppy);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard state (owned by the monitor)
  typedef struct { int mag; int sign; } res_t;
  res_t       sb[$];
  int         ent[$];
  int         age;
  logic [7:0] fc_model;
  bit         prev_rst;

  always @(negedge clk) begin
    if (reset) begin
      if (prev_rst) begin
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_mag", int'(bus.out_mag), 0);
        chk("rst_out_sign", int'(bus.out_sign), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_mats", int'({mat_a, mat_b, mat_c, mat_d}), 0);
      end
      chk("rst_in_ready", int'(bus.in_ready), 0);
      sb.delete();
      ent.delete();
      age      = 0;
      fc_model = 8'd0;
      prev_rst = 1'b1;
    end else begin
      bit exp_ready;
      prev_rst  = 1'b0;
      exp_ready = (sb.size() == 0);
      chk("in_ready", int'(bus.in_ready), int'(exp_ready));
      chk("frame_cnt", int'(frame_cnt), int'(fc_model));
      if (sb.size() != 0) begin
        age++;
        chk("out_valid", int'(bus.out_valid), (age >= 2) ? 1 : 0);
        if (age >= 2) begin
          chk("out_mag", int'(bus.out_mag), sb[0].mag);
          chk("out_sign", int'(bus.out_sign), sb[0].sign);
          if (bus.out_ready) begin
            void'(sb.pop_front());
            fc_model = fc_model + 8'd1;
            age      = 0;
          end
        end
      end else begin
        chk("out_valid_idle", int'(bus.out_valid), 0);
      end
      if (exp_ready && bus.in_valid && bus.in_ready) begin
        ent.push_back(int'(bus.in_data));
        if (ent.size() == 4) begin
          res_t r;
          int   v;
          v      = ent[0] * ent[3] - ent[2] * ent[1];
          r.mag  = (v < 0) ? -v : v;
          r.sign = (v < 0) ? 1 : 0;
          sb.push_back(r);
          ent.delete();
          age = 0;
        end
      end
    end
  end

  // Consumer: 0 = stall, 1 = always ready, 2 = random
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send_entry(input logic [3:0] v, input int gap);
    bit got;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    sloppy       = 1'($urandom);
    got          = 1'b0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 4'($urandom);
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_matrix(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d, input int gap);
    send_entry(a, gap);
    send_entry(b, gap);
    send_entry(c, gap);
    send_entry(d, gap);
  endtask

  task automatic do_reset(input int n);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !bus.out_valid;
    end
    @(posedge clk);
    #1;
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    sloppy       = 1'b0;
    or_mode      = 1;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed patterns: positive, negative with gaps, zero, extremes
    send_matrix(4'd3, 4'd2, 4'd1, 4'd4, 0);
    drain();
    chk("frame_cnt_after_first", int'(frame_cnt), 1);
    send_matrix(4'd1, 4'd5, 4'd3, 4'd2, 2);
    drain();
    send_entry(4'd2, 0);
    send_entry(4'd4, 0);
    send_entry(4'd1, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd2;
    sloppy       = 1'b1;
    send_entry(4'd2, 0);
    sloppy = 1'b1;
    drain();
    send_matrix(4'd15, 4'd0, 4'd0, 4'd15, 0);
    drain();
    send_matrix(4'd0, 4'd15, 4'd15, 4'd0, 0);
    drain();

    // Backpressure: stall 12 cycles while the next matrix is offered
    or_mode = 0;
    send_matrix(4'd7, 4'd3, 4'd2, 4'd5, 0);
    fork
      send_matrix(4'd9, 4'd1, 4'd4, 4'd6, 0);
      begin
        repeat (12) @(posedge clk);
        #1;
        or_mode = 1;
      end
    join
    drain();

    // Reset after two entries, then a fresh matrix
    send_entry(4'd11, 0);
    send_entry(4'd13, 0);
    do_reset(2);
    send_matrix(4'd6, 4'd2, 4'd8, 4'd1, 0);
    drain();

    // Reset while holding a result
    or_mode = 0;
    send_matrix(4'd5, 4'd9, 4'd2, 4'd14, 0);
    repeat (4) @(posedge clk);
    #1;
    do_reset(2);
    or_mode = 1;
    send_matrix(4'd12, 4'd3, 4'd10, 4'd4, 1);
    drain();

    // Random phase; also takes frame_cnt through its wrap
    for (int m = 0; m < 300; m++) begin
      or_mode = (m % 50 < 10) ? 1 : 2;
      send_matrix(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  int'($urandom_range(0, 2)));
    end
    or_mode = 1;
    drain();
    chk("frame_cnt_final", int'(frame_cnt), 301 % 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end
endmodule
